// File: rtl/recirc_link_ctrl.sv
// Link-activation controller: qualifies the incoming word stream with a run of COM
// words, raises active for the recirculator, and drops it after a run of idle cycles.
module recirc_link_ctrl #(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] COM_WORD  = WIDTH'(32'hBCBCBCBC),
  parameter int unsigned     SYNC_COUNT = 4,
  parameter int unsigned     LOSS_COUNT = 3
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_input,
  input  logic             valid,
  output logic             active,
  output logic [1:0]       state,
  output logic [15:0]      fwd_count,
  output logic             loss_pulse
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned FWD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             active_q, active_d;
  logic [FWD_W-1:0] fwd_q, fwd_d;
  logic             loss_pulse_q, loss_pulse_d;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  logic             is_com_c;
  logic [CNT_W:0]   sync_inc_c, loss_inc_c;
  logic             sync_last_c, loss_last_c;

  // Shared decode of the sampled word and the counter terminal conditions
  assign is_com_c    = valid && (data_input == COM_WORD);
  assign sync_inc_c  = {1'b0, sync_cnt_q} + (CNT_W+1)'(1);
  assign loss_inc_c  = {1'b0, loss_cnt_q} + (CNT_W+1)'(1);
  assign sync_last_c = (sync_inc_c == (CNT_W+1)'(SYNC_COUNT));
  assign loss_last_c = (loss_inc_c == (CNT_W+1)'(LOSS_COUNT));

  // State and output registers
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      active_q     <= 1'b0;
      fwd_q        <= '0;
      loss_pulse_q <= 1'b0;
      sync_cnt_q   <= '0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      fwd_q        <= fwd_d;
      loss_pulse_q <= loss_pulse_d;
      sync_cnt_q   <= sync_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_com_c) state_d = (SYNC_COUNT == 1) ? ST_ACTIVE : ST_SYNC;
      end
      ST_SYNC: begin
        if (is_com_c) begin
          if (sync_last_c) state_d = ST_ACTIVE;
        end else if (valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!valid && loss_last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    active_d     = active_q;
    fwd_d        = fwd_q;
    loss_pulse_d = 1'b0;
    sync_cnt_d   = sync_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        active_d = 1'b0;
        if (is_com_c) begin
          if (SYNC_COUNT == 1) begin
            active_d   = 1'b1;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = CNT_W'(1);
          end
        end else begin
          sync_cnt_d = '0;
        end
      end
      ST_SYNC: begin
        if (is_com_c) begin
          if (sync_last_c) begin
            active_d   = 1'b1;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_inc_c[CNT_W-1:0];
          end
        end else if (valid) begin
          sync_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (valid) begin
          loss_cnt_d = '0;
          if (fwd_q != {FWD_W{1'b1}}) fwd_d = fwd_q + FWD_W'(1);
        end else if (loss_last_c) begin
          active_d     = 1'b0;
          loss_pulse_d = 1'b1;
          loss_cnt_d   = '0;
        end else begin
          loss_cnt_d = loss_inc_c[CNT_W-1:0];
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean idle
        active_d   = 1'b0;
        sync_cnt_d = '0;
        loss_cnt_d = '0;
      end
    endcase
  end

  assign active     = active_q;
  assign state      = state_q;
  assign fwd_count  = fwd_q;
  assign loss_pulse = loss_pulse_q;

endmodule

// File: tb/tb_recirc_link_ctrl.sv
// Bench for recirc_link_ctrl: a default instance (SYNC 4 / LOSS 3) and a SYNC 1 / LOSS 1
// instance share stimulus; a link model is compared every cycle plus literal spot checks.
module tb_recirc_link_ctrl;

  localparam logic [31:0] COM = 32'hBCBCBCBC;

  logic        clk_2f = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] data_input = 32'h0;
  logic        valid = 1'b0;

  logic        act0, act1, lp0, lp1;
  logic [1:0]  st0, st1;
  logic [15:0] fc0, fc1;

  int checks   = 0;
  int failures = 0;

  recirc_link_ctrl #(.WIDTH(32), .COM_WORD(COM), .SYNC_COUNT(4), .LOSS_COUNT(3)) u_dut0 (
    .clk_2f(clk_2f), .reset(reset), .data_input(data_input), .valid(valid),
    .active(act0), .state(st0), .fwd_count(fc0), .loss_pulse(lp0));

  recirc_link_ctrl #(.WIDTH(32), .COM_WORD(COM), .SYNC_COUNT(1), .LOSS_COUNT(1)) u_dut1 (
    .clk_2f(clk_2f), .reset(reset), .data_input(data_input), .valid(valid),
    .active(act1), .state(st1), .fwd_count(fc1), .loss_pulse(lp1));

  always #5 clk_2f = ~clk_2f;

  function automatic int sync_need(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int loss_need(int i);
    return (i == 0) ? 3 : 1;
  endfunction

  // Link model: link flag, COM run length, idle run length, accepted-word total
  bit m_link[2];
  int m_run[2];
  int m_miss[2];
  int m_fwd[2];
  bit m_pulse[2];

  always @(posedge clk_2f or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_link[i] <= 1'b0; m_run[i] <= 0; m_miss[i] <= 0; m_fwd[i] <= 0; m_pulse[i] <= 1'b0;
      end else begin
        m_pulse[i] <= 1'b0;
        if (!m_link[i]) begin
          if (valid && data_input == COM) begin
            if (m_run[i] + 1 >= sync_need(i)) begin
              m_link[i] <= 1'b1; m_run[i] <= 0;
            end else begin
              m_run[i] <= m_run[i] + 1;
            end
          end else if (valid) begin
            m_run[i] <= 0;
          end
        end else if (valid) begin
          m_miss[i] <= 0;
          m_fwd[i]  <= (m_fwd[i] >= 65535) ? 65535 : m_fwd[i] + 1;
        end else if (m_miss[i] + 1 >= loss_need(i)) begin
          m_link[i] <= 1'b0; m_miss[i] <= 0; m_pulse[i] <= 1'b1;
        end else begin
          m_miss[i] <= m_miss[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", name, idx, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_state(int i);
    if (m_link[i]) return 32'd2;
    return (m_run[i] > 0) ? 32'd1 : 32'd0;
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk_2f) begin
    chk("m_active", 0, 32'(act0), 32'(m_link[0]));
    chk("m_state",  0, 32'(st0),  model_state(0));
    chk("m_fwd",    0, 32'(fc0),  32'(m_fwd[0]));
    chk("m_pulse",  0, 32'(lp0),  32'(m_pulse[0]));
    chk("m_active", 1, 32'(act1), 32'(m_link[1]));
    chk("m_state",  1, 32'(st1),  model_state(1));
    chk("m_fwd",    1, 32'(fc1),  32'(m_fwd[1]));
    chk("m_pulse",  1, 32'(lp1),  32'(m_pulse[1]));
  end

  // Present one word and let the next edge sample it
  task automatic send(input logic v, input logic [31:0] d);
    valid      = v;
    data_input = d;
    @(posedge clk_2f);
    #1;
  endtask

  logic vpat [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    // T1: inputs toggling under reset
    send(1'b1, COM); send(1'b1, COM); send(1'b0, 32'h1); send(1'b1, COM);
    chk("t1_active", 0, 32'(act0), 32'd0);
    chk("t1_state",  0, 32'(st0),  32'd0);
    chk("t1_fwd",    0, 32'(fc0),  32'd0);
    chk("t1_pulse",  0, 32'(lp0),  32'd0);
    reset = 1'b1;

    // T2: four COM words
    chk("t2_state0", 0, 32'(st0), 32'd0);
    send(1'b1, COM);
    chk("t2_state1", 0, 32'(st0), 32'd1);
    chk("t2_direct_state", 1, 32'(st1), 32'd2);
    chk("t2_direct_active", 1, 32'(act1), 32'd1);
    send(1'b1, COM);
    chk("t2_state2", 0, 32'(st0), 32'd1);
    send(1'b1, COM);
    chk("t2_state3", 0, 32'(st0), 32'd1);
    chk("t2_notyet", 0, 32'(act0), 32'd0);
    send(1'b1, COM);
    chk("t2_state4", 0, 32'(st0), 32'd2);
    chk("t2_active", 0, 32'(act0), 32'd1);

    // T4: ten valid words with two isolated idle cycles
    for (int k = 0; k < 12; k++) send(vpat[k], 32'h1000 + 32'(k));
    chk("t4_active", 0, 32'(act0), 32'd1);
    chk("t4_fwd",    0, 32'(fc0),  32'd10);

    // T5: three idle cycles drop the link
    send(1'b0, 32'h0);
    chk("t5_hold1", 0, 32'(act0), 32'd1);
    send(1'b0, 32'h0);
    chk("t5_hold2", 0, 32'(act0), 32'd1);
    send(1'b0, 32'h0);
    chk("t5_active", 0, 32'(act0), 32'd0);
    chk("t5_state",  0, 32'(st0),  32'd0);
    chk("t5_pulse",  0, 32'(lp0),  32'd1);
    send(1'b0, 32'h0);
    chk("t5_pulse_end", 0, 32'(lp0), 32'd0);
    chk("t5_fwd_kept",  0, 32'(fc0), 32'd10);

    // T2 gap: one idle cycle inside the COM run
    send(1'b1, COM);
    chk("gap_direct", 1, 32'(st1), 32'd2);
    send(1'b1, COM);
    send(1'b0, 32'h0);
    chk("gap_hold", 0, 32'(st0), 32'd1);
    send(1'b1, COM);
    chk("gap_notyet", 0, 32'(act0), 32'd0);
    send(1'b1, COM);
    chk("gap_active", 0, 32'(act0), 32'd1);
    chk("gap_state",  0, 32'(st0),  32'd2);

    // T3: non-COM valid word aborts sync
    repeat (3) send(1'b0, 32'h0);
    send(1'b1, COM); send(1'b1, COM);
    send(1'b1, 32'h12345678);
    chk("t3_abort", 0, 32'(st0), 32'd0);
    repeat (3) send(1'b1, COM);
    chk("t3_notyet", 0, 32'(act0), 32'd0);
    send(1'b1, COM);
    chk("t3_active", 0, 32'(act0), 32'd1);

    // T6: saturation of the forwarded-word count
    for (int k = 0; k < 65540; k++) send(1'b1, 32'(k));
    chk("t6_sat", 0, 32'(fc0), 32'h0000FFFF);
    chk("t6_active", 0, 32'(act0), 32'd1);

    // Asynchronous reset mid-cycle
    @(posedge clk_2f);
    #2 reset = 1'b0;
    #1;
    chk("async_active", 0, 32'(act0), 32'd0);
    chk("async_state",  0, 32'(st0),  32'd0);
    chk("async_fwd",    0, 32'(fc0),  32'd0);
    chk("async_fwd",    1, 32'(fc1),  32'd0);
    repeat (2) @(posedge clk_2f);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
